// File: rtl/ysyx_24080006_axi_sram_pkg.sv
// Shared types for the AXI SRAM slave: reduced AXI channel structs, FSM state enums, default depth.
package ysyx_24080006_pkg;

  localparam int unsigned SramDepthLog2 = 16;
  localparam logic [1:0]  AxiBurstFixed = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DATA, W_RESP} sram_w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} sram_r_state_e;

  typedef struct packed {
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
  } axi_w_m2s_t;

  typedef struct packed {
    logic awready;
    logic wready;
    logic bvalid;
  } axi_w_s2m_t;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } axi_r_s2m_t;

endpackage

// File: rtl/ysyx_24080006_axi_sram_if.sv
// Bundle of the four reduced AXI channel structs between a master and the SRAM slave.
// Every channel transfers on a rising clock edge where its valid and ready are both high;
// a source holds valid and its payload stable until that edge, and ready may not depend on a later valid.
interface ysyx_24080006_axi_sram_if;
  import ysyx_24080006_pkg::*;

  axi_w_m2s_t w_m2s;
  axi_w_s2m_t w_s2m;
  axi_r_m2s_t r_m2s;
  axi_r_s2m_t r_s2m;

  modport master (output w_m2s, output r_m2s, input w_s2m, input r_s2m);
  modport slave  (input w_m2s, input r_m2s, output w_s2m, output r_s2m);
endinterface

// File: rtl/ysyx_24080006_axi_sram_beat.sv
// Burst address walker: latches the request, steps per beat (FIXED holds, INCR/WRAP add 1<<size).
module ysyx_24080006_axi_sram_beat
  import ysyx_24080006_pkg::*;
#(
  parameter int unsigned MemDepthLog2 = SramDepthLog2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic [31:0]             addr_i,
  input  logic [7:0]              len_i,
  input  logic [2:0]              size_i,
  input  logic [1:0]              burst_i,
  input  logic                    step_i,
  output logic [MemDepthLog2-1:0] idx_o,
  output logic [MemDepthLog2-1:0] next_idx_o,
  output logic                    last_o
);

  logic [31:0] addr_q, addr_d, next_addr;
  logic [7:0]  len_q, len_d, cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;

  assign next_addr = (burst_q == AxiBurstFixed) ? addr_q : addr_q + (32'd1 << size_q);

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      addr_d  = addr_i;
      len_d   = len_i;
      size_d  = size_i;
      burst_d = burst_i;
      cnt_d   = 8'd0;
    end else if (step_i) begin
      addr_d = next_addr;
      cnt_d  = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idx_o      = addr_q[MemDepthLog2+1:2];
  assign next_idx_o = next_addr[MemDepthLog2+1:2];
  assign last_o     = (cnt_q == len_q);

endmodule

// File: rtl/ysyx_24080006_axi_sram.sv
// AXI4 burst slave memory with independent read and write FSMs over a 32-bit word array.
// Define YSYX_24080006_SRAM_DELAY_EN to add RespDelay wait cycles before the first R beat and before B.
module ysyx_24080006_axi_sram
  import ysyx_24080006_pkg::*;
#(
  parameter int unsigned MemDepthLog2 = SramDepthLog2,
  parameter int unsigned RespDelay    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  ysyx_24080006_axi_sram_if.slave bus,
  output sram_w_state_e           w_state_o,
  output sram_r_state_e           r_state_o
);

  localparam int unsigned Depth = 1 << MemDepthLog2;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;
  logic        live_q;

  sram_w_state_e w_state_q, w_state_d;
  sram_r_state_e r_state_q, r_state_d;

  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic w_last, r_last, w_wait_done, r_wait_done;
  logic [MemDepthLog2-1:0] w_idx, w_next_idx_unused, r_idx_unused, r_next_idx, ar_idx;
  logic unused_wlast;

  assign aw_fire = awready && bus.w_m2s.awvalid;
  assign w_fire  = wready  && bus.w_m2s.wvalid;
  assign b_fire  = bvalid  && bus.w_m2s.bready;
  assign ar_fire = arready && bus.r_m2s.arvalid;
  assign r_fire  = rvalid  && bus.r_m2s.rready;
  assign ar_idx  = bus.r_m2s.araddr[MemDepthLog2+1:2];
  // The beat counter alone ends a write burst.
  assign unused_wlast = bus.w_m2s.wlast;

  ysyx_24080006_axi_sram_beat #(.MemDepthLog2(MemDepthLog2)) u_w_beat (
    .clock      (clock),
    .reset      (reset),
    .load_i     (aw_fire),
    .addr_i     (bus.w_m2s.awaddr),
    .len_i      (bus.w_m2s.awlen),
    .size_i     (bus.w_m2s.awsize),
    .burst_i    (bus.w_m2s.awburst),
    .step_i     (w_fire),
    .idx_o      (w_idx),
    .next_idx_o (w_next_idx_unused),
    .last_o     (w_last)
  );

  ysyx_24080006_axi_sram_beat #(.MemDepthLog2(MemDepthLog2)) u_r_beat (
    .clock      (clock),
    .reset      (reset),
    .load_i     (ar_fire),
    .addr_i     (bus.r_m2s.araddr),
    .len_i      (bus.r_m2s.arlen),
    .size_i     (bus.r_m2s.arsize),
    .burst_i    (bus.r_m2s.arburst),
    .step_i     (r_fire),
    .idx_o      (r_idx_unused),
    .next_idx_o (r_next_idx),
    .last_o     (r_last)
  );

`ifdef YSYX_24080006_SRAM_DELAY_EN
  localparam logic [7:0]    DelayInit  = 8'(RespDelay);
  localparam sram_w_state_e WAfterLast = sram_w_state_e'((RespDelay == 0) ? W_RESP : W_WAIT);
  localparam sram_r_state_e RAfterAr   = sram_r_state_e'((RespDelay == 0) ? R_DATA : R_WAIT);
  logic [7:0] w_dly_q, w_dly_d, r_dly_q, r_dly_d;

  always_comb begin
    w_dly_d = w_dly_q;
    r_dly_d = r_dly_q;
    if (w_fire && w_last)          w_dly_d = DelayInit;
    else if (w_state_q == W_WAIT)  w_dly_d = w_dly_q - 8'd1;
    if (ar_fire)                   r_dly_d = DelayInit;
    else if (r_state_q == R_WAIT)  r_dly_d = r_dly_q - 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_dly_q <= '0;
      r_dly_q <= '0;
    end else begin
      w_dly_q <= w_dly_d;
      r_dly_q <= r_dly_d;
    end
  end

  assign w_wait_done = (w_dly_q == 8'd1);
  assign r_wait_done = (r_dly_q == 8'd1);
`else
  localparam sram_w_state_e WAfterLast      = W_RESP;
  localparam sram_r_state_e RAfterAr        = R_DATA;
  localparam int unsigned   UnusedRespDelay = RespDelay;
  assign w_wait_done = 1'b1;
  assign r_wait_done = 1'b1;
`endif

  // live_q keeps both address channels closed until the first edge after reset releases.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live_q    <= 1'b0;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      live_q    <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_fire)          w_state_d = W_DATA;
      W_DATA:  if (w_fire && w_last) w_state_d = WAfterLast;
      W_WAIT:  if (w_wait_done)      w_state_d = W_RESP;
      W_RESP:  if (b_fire)           w_state_d = W_IDLE;
      default:                       w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_fire)          r_state_d = RAfterAr;
      R_WAIT:  if (r_wait_done)      r_state_d = R_DATA;
      R_DATA:  if (r_fire && r_last) r_state_d = R_IDLE;
      default:                       r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    awready = live_q && (w_state_q == W_IDLE);
    wready  = (w_state_q == W_DATA);
    bvalid  = (w_state_q == W_RESP);
    arready = live_q && (r_state_q == R_IDLE);
    rvalid  = (r_state_q == R_DATA);
    rlast   = rvalid && r_last;
  end

  assign bus.w_s2m = '{awready: awready, wready: wready, bvalid: bvalid};
  assign bus.r_s2m = '{arready: arready, rvalid: rvalid, rdata: rdata_q, rlast: rlast};
  assign w_state_o = w_state_q;
  assign r_state_o = r_state_q;

  always_ff @(posedge clock) begin
    if (w_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.w_m2s.wstrb[b]) mem_q[w_idx][8*b +: 8] <= bus.w_m2s.wdata[8*b +: 8];
      end
    end
  end

  // Nonblocking reads of mem_q see the pre-write word when a write lands on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                rdata_q <= '0;
    else if (ar_fire)         rdata_q <= mem_q[ar_idx];
    else if (r_fire && !r_last) rdata_q <= mem_q[r_next_idx];
  end

endmodule

// File: tb/tb_ysyx_24080006_axi_sram.sv
// Scoreboard bench for the AXI SRAM slave: driver tasks, word-array reference model, R-channel monitor.
module tb_ysyx_24080006_axi_sram;
  import ysyx_24080006_pkg::*;

  localparam int unsigned RespDelay = 4;
  localparam int Tmo = 64;
`ifdef YSYX_24080006_SRAM_DELAY_EN
  localparam int ExpLat = RespDelay;
`else
  localparam int ExpLat = 0;
`endif

  logic clock, reset;
  sram_w_state_e w_state;
  sram_r_state_e r_state;
  ysyx_24080006_axi_sram_if bus();

  ysyx_24080006_axi_sram #(.MemDepthLog2(16), .RespDelay(RespDelay)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .w_state_o (w_state),
    .r_state_o (r_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model_mem [int];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model: 2^16 words, address bits above 17 alias
  function automatic int widx(input logic [31:0] a);
    return int'(a[17:2]);
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b00) return a;
    return a + (32'd1 << size);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int k = widx(a);
    if (model_mem.exists(k)) return model_mem[k];
    return 32'h0;
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w = model_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    model_mem[widx(a)] = w;
  endfunction

  // monitor: every R handshake pops one expected {rlast, rdata}
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clock);
      if (!reset && bus.r_s2m.rvalid && bus.r_m2s.rready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL r_unexpected: got beat %0h expected none", bus.r_s2m.rdata);
        end else begin
          e = exp_q.pop_front();
          check("rdata", bus.r_s2m.rdata, e[31:0]);
          check("rlast", bus.r_s2m.rlast, e[32]);
        end
      end
    end
  end

  task automatic wr_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int b_hold);
    logic [31:0] a;
    int cnt;
    a = addr;
    @(posedge clock); #1;
    bus.w_m2s.awvalid = 1'b1;
    bus.w_m2s.awaddr  = addr;
    bus.w_m2s.awlen   = 8'(len);
    bus.w_m2s.awsize  = size;
    bus.w_m2s.awburst = burst;
    cnt = 0;
    @(negedge clock);
    while (!bus.w_s2m.awready && cnt < Tmo) begin @(negedge clock); cnt++; end
    check("aw_accept", cnt < Tmo, 1);
    @(posedge clock); #1;
    bus.w_m2s.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.w_m2s.wvalid = 1'b1;
      bus.w_m2s.wdata  = wd_q[i];
      bus.w_m2s.wstrb  = ws_q[i];
      bus.w_m2s.wlast  = (i == len);
      cnt = 0;
      @(negedge clock);
      while (!bus.w_s2m.wready && cnt < Tmo) begin @(negedge clock); cnt++; end
      check("w_ready_wait", cnt, 0);
      model_wr(a, wd_q[i], ws_q[i]);
      a = nxt(a, size, burst);
      @(posedge clock); #1;
    end
    bus.w_m2s.wvalid = 1'b0;
    bus.w_m2s.wlast  = 1'b0;
    bus.w_m2s.bready = 1'b0;
    cnt = 0;
    @(negedge clock);
    while (!bus.w_s2m.bvalid && cnt < Tmo) begin @(negedge clock); cnt++; end
    check("b_latency", cnt, ExpLat);
    for (int h = 0; h < b_hold; h++) begin
      @(negedge clock);
      check("b_hold", bus.w_s2m.bvalid, 1);
    end
    @(posedge clock); #1;
    bus.w_m2s.bready = 1'b1;
    @(posedge clock); #1;
    bus.w_m2s.bready = 1'b0;
    @(negedge clock);
    check("awready_after_b", bus.w_s2m.awready, 1);
    check("bvalid_after_b", bus.w_s2m.bvalid, 0);
  endtask

  task automatic rd_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int stall_beat, input int stall_cyc,
                          input bit gaps);
    logic [31:0] a;
    int cnt, hold;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      exp_q.push_back({(i == len), model_rd(a)});
      a = nxt(a, size, burst);
    end
    @(posedge clock); #1;
    bus.r_m2s.arvalid = 1'b1;
    bus.r_m2s.araddr  = addr;
    bus.r_m2s.arlen   = 8'(len);
    bus.r_m2s.arsize  = size;
    bus.r_m2s.arburst = burst;
    cnt = 0;
    @(negedge clock);
    while (!bus.r_s2m.arready && cnt < Tmo) begin @(negedge clock); cnt++; end
    check("ar_accept", cnt < Tmo, 1);
    @(posedge clock); #1;
    bus.r_m2s.arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      hold = (i == stall_beat) ? stall_cyc : ((gaps && i > 0) ? $urandom_range(0, 2) : 0);
      if (hold > 0) begin
        bus.r_m2s.rready = 1'b0;
        for (int s = 0; s < hold; s++) begin
          @(negedge clock);
          if (i == stall_beat && exp_q.size() > 0) begin
            check("stall_rvalid", bus.r_s2m.rvalid, 1);
            check("stall_rdata", bus.r_s2m.rdata, exp_q[0][31:0]);
            check("stall_rlast", bus.r_s2m.rlast, exp_q[0][32]);
          end
          @(posedge clock); #1;
        end
      end
      bus.r_m2s.rready = 1'b1;
      cnt = 0;
      @(negedge clock);
      if (i == 0) check("arready_busy", bus.r_s2m.arready, 0);
      while (!bus.r_s2m.rvalid && cnt < Tmo) begin @(negedge clock); cnt++; end
      if (i == 0) check("r_latency", cnt, ExpLat);
      else        check("r_beat_wait", cnt, 0);
      @(posedge clock); #1;
    end
    bus.r_m2s.rready = 1'b0;
    @(negedge clock);
    check("arready_after_rlast", bus.r_s2m.arready, 1);
  endtask

  task automatic fill(input int len, input bit rnd_strb);
    wd_q.delete();
    ws_q.delete();
    for (int i = 0; i <= len; i++) begin
      wd_q.push_back($urandom);
      ws_q.push_back(rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF);
    end
  endtask

  task automatic put(input logic [31:0] d, input logic [3:0] s);
    wd_q.push_back(d);
    ws_q.push_back(s);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_awready"}, bus.w_s2m.awready, 0);
    check({tag, "_wready"},  bus.w_s2m.wready, 0);
    check({tag, "_bvalid"},  bus.w_s2m.bvalid, 0);
    check({tag, "_arready"}, bus.r_s2m.arready, 0);
    check({tag, "_rvalid"},  bus.r_s2m.rvalid, 0);
    check({tag, "_rlast"},   bus.r_s2m.rlast, 0);
    check({tag, "_rdata"},   bus.r_s2m.rdata, 0);
  endtask

  initial begin
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          len, cnt;

    bus.w_m2s = '0;
    bus.r_m2s = '0;
    reset = 1'b1;
    #1;
    check_outputs_zero("rst");
    check("rst_w_state", w_state, W_IDLE);
    check("rst_r_state", r_state, R_IDLE);
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
    check("awready_pre_edge", bus.w_s2m.awready, 0);
    check("arready_pre_edge", bus.r_s2m.arready, 0);
    @(posedge clock); #1;
    check("awready_post_edge", bus.w_s2m.awready, 1);
    check("arready_post_edge", bus.r_s2m.arready, 1);

    // prefill 0x1000..0x13FF and 0x200..0x20C with known data
    fill(255, 1'b0);
    wr_burst(32'h1000, 255, 3'd2, 2'b01, 0);
    wd_q.delete(); ws_q.delete();
    for (int i = 0; i < 4; i++) put(32'hA0 + 32'(i), 4'hF);
    wr_burst(32'h200, 3, 3'd2, 2'b01, 1);

    // single beat, then read back directly and through an aliased address
    wd_q.delete(); ws_q.delete();
    put(32'hDEADBEEF, 4'hF);
    wr_burst(32'h8000_0010, 0, 3'd2, 2'b01, 0);
    rd_burst(32'h8000_0010, 0, 3'd2, 2'b01, -1, 0, 1'b0);
    rd_burst(32'h0000_0010, 0, 3'd2, 2'b01, -1, 0, 1'b0);

    // INCR burst 1,2,3,4
    wd_q.delete(); ws_q.delete();
    for (int i = 1; i <= 4; i++) put(32'(i), 4'hF);
    wr_burst(32'h100, 3, 3'd2, 2'b01, 0);
    rd_burst(32'h100, 3, 3'd2, 2'b01, -1, 0, 1'b0);

    // byte-lane merge
    wd_q.delete(); ws_q.delete();
    put(32'h11223344, 4'hF);
    wr_burst(32'h300, 0, 3'd2, 2'b01, 0);
    wd_q.delete(); ws_q.delete();
    put(32'h0000AA00, 4'b0010);
    wr_burst(32'h300, 0, 3'd2, 2'b01, 0);
    check("merge_model", model_rd(32'h300), 32'h1122AA44);
    rd_burst(32'h300, 0, 3'd2, 2'b01, -1, 0, 1'b0);

    // FIXED burst lands all beats on one word
    wd_q.delete(); ws_q.delete();
    for (int i = 5; i <= 8; i++) put(32'(i), 4'hF);
    wr_burst(32'h200, 3, 3'd2, 2'b00, 0);
    rd_burst(32'h200, 1, 3'd2, 2'b01, -1, 0, 1'b0);

    // read stalls at beat 2 while a write burst runs on the other channel
    fill(7, 1'b0);
    fork
      rd_burst(32'h1000, 7, 3'd2, 2'b01, 2, 3, 1'b0);
      wr_burst(32'h2000, 7, 3'd2, 2'b01, 0);
    join
    rd_burst(32'h2000, 7, 3'd2, 2'b10, -1, 0, 1'b0);

    // randomized bursts inside the prefilled region, random upper (aliased) address bits
    for (int t = 0; t < 24; t++) begin
      size  = 3'($urandom_range(0, 2));
      burst = 2'($urandom_range(0, 2));
      len   = $urandom_range(0, 15);
      addr  = 32'h1000 + 32'($urandom_range(0, 'h3BF));
      addr  = addr & ~((32'd1 << size) - 32'd1);
      addr  = {14'($urandom), addr[17:0]};
      if ($urandom_range(0, 1) == 1) begin
        fill(len, 1'b1);
        wr_burst(addr, len, size, burst, $urandom_range(0, 2));
      end else begin
        rd_burst(addr, len, size, burst, -1, 0, 1'b1);
      end
    end

    // reset during the third beat of a four-beat write
    wd_q.delete(); ws_q.delete();
    for (int i = 0; i < 4; i++) put(32'h5500 + 32'(i), 4'hF);
    @(posedge clock); #1;
    bus.w_m2s.awvalid = 1'b1;
    bus.w_m2s.awaddr  = 32'h1040;
    bus.w_m2s.awlen   = 8'd3;
    bus.w_m2s.awsize  = 3'd2;
    bus.w_m2s.awburst = 2'b01;
    cnt = 0;
    @(negedge clock);
    while (!bus.w_s2m.awready && cnt < Tmo) begin @(negedge clock); cnt++; end
    check("rst_aw_accept", cnt < Tmo, 1);
    @(posedge clock); #1;
    bus.w_m2s.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.w_m2s.wvalid = 1'b1;
      bus.w_m2s.wdata  = wd_q[i];
      bus.w_m2s.wstrb  = 4'hF;
      @(negedge clock);
      check("rst_wready", bus.w_s2m.wready, 1);
      model_wr(32'h1040 + 32'(4 * i), wd_q[i], 4'hF);
      @(posedge clock); #1;
    end
    bus.w_m2s.wdata = wd_q[2];
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("midrst");
    check("midrst_w_state", w_state, W_IDLE);
    bus.w_m2s.wvalid = 1'b0;
    @(posedge clock);
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
    check("midrst_awready_pre", bus.w_s2m.awready, 0);
    @(posedge clock); #1;
    check("midrst_awready_post", bus.w_s2m.awready, 1);
    check("midrst_arready_post", bus.r_s2m.arready, 1);
    rd_burst(32'h1040, 3, 3'd2, 2'b01, -1, 0, 1'b0);
    fill(3, 1'b0);
    wr_burst(32'h1040, 3, 3'd2, 2'b01, 0);
    rd_burst(32'h1040, 3, 3'd2, 2'b01, -1, 0, 1'b1);

    repeat (4) @(negedge clock);
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_axi_sram.md
# ysyx_24080006_axi_sram

AXI4 burst-capable slave-side memory that responds to the core's AXI master ports (instruction fetch, LSU, cache refill). It accepts write and read bursts on the reduced `axi_*_m2s_t` / `axi_*_s2m_t` channel structs and backs them with a word-organised on-chip array. Write and read channels run independent state machines, so one read burst and one write burst can be in flight at the same time. Used as simulation main memory and as a standalone target for master-side verification.

## Interface
Parameters:
- `MemDepthLog2`, 16: log2 of array depth in 32-bit words; word index = `addr[MemDepthLog2+1:2]`, upper address bits ignored (aliasing).
- `RespDelay`, 4: extra wait cycles before first R beat and before B; used only with the delay macro.

Ports:
- `clock`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `w_m2s`  in  `axi_w_m2s_t`  AW/W/B master signals.
- `w_s2m`  out  `axi_w_s2m_t`  awready, wready, bvalid.
- `r_m2s`  in  `axi_r_m2s_t`  AR/R master signals.
- `r_s2m`  out  `axi_r_s2m_t`  arready, rvalid, rdata, rlast.

## Operation
- No error responses: the structs carry no bresp/rresp, so every access succeeds.
- Write FSM: W_IDLE (awready=1) → W_DATA (wready=1) → W_RESP (bvalid=1) → W_IDLE.
  - AW handshake latches awaddr, awlen, awsize, awburst and clears the beat counter.
  - Each W handshake writes the byte lanes enabled by wstrb to the current word.
  - Burst 00 (FIXED) holds the address; 01 and 10 both increment it by `1<<awsize` (WRAP is treated as INCR).
  - The beat counter alone ends the burst at beat awlen; wlast is not checked.
  - W_RESP holds bvalid until bready.
- Read FSM: R_IDLE (arready=1) → R_DATA (rvalid=1) → R_IDLE.
  - AR handshake latches the request and loads the registered rdata from the first word.
  - Each R handshake loads rdata from the next address, with the same increment rule as writes.
  - rlast=1 only when the beat counter equals arlen; the handshake with rlast returns the FSM to R_IDLE.
- Narrow transfers: read returns the full aligned word; the master selects lanes. On write, wstrb alone selects bytes.
- Collision: when rdata loads from a word in the same cycle that word is written, rdata gets the old contents (read-before-write).
- Memory contents are not reset.

## Timing
- Reset values:
  - awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, rdata=0.
  - Both FSMs go to IDLE.
  - awready and arready rise on the first clock edge after reset deasserts.
- Read:
  - AR accepted at edge t → rvalid=1 from t+1.
  - With rready held high, one beat per cycle.
  - While rready=0, rdata and rlast stay stable.
  - arready=0 from t+1 until the cycle after the rlast handshake.
- Write:
  - AW accepted at t → wready from t+1.
  - Last W handshake at t' → bvalid from t'+1.
  - B handshake at t'' → awready=1 at t''+1.
- Read and write channels never stall each other.
- Reset asserted mid-burst aborts both bursts immediately; writes already committed remain in the array.

## Configuration
- `YSYX_24080006_SRAM_DELAY_EN`
  - Defined: adds R_WAIT and W_WAIT states with a down-counter loaded with RespDelay. First rvalid arrives RespDelay+1 cycles after AR acceptance; bvalid arrives RespDelay+1 cycles after the last W beat. Later R beats are not delayed.
  - Undefined: the wait states and counter are absent, and the latencies in Timing apply.

## Structure
- Add to `ysyx_24080006_pkg`:
  - `sram_w_state_e` (W_IDLE, W_WAIT, W_DATA, W_RESP)
  - `sram_r_state_e` (R_IDLE, R_WAIT, R_DATA)
  - `localparam SramDepthLog2 = 16`
- Sub-module `ysyx_24080006_axi_sram_beat`: latches addr/len/size/burst, advances on a step input, outputs word index and a last flag. Instantiated once per channel.

## Test plan
- Single write 0x8000_0010, len 0, size 2, wdata 0xDEADBEEF, wstrb 0xF → bvalid one cycle after the W beat; a read of the same address returns 0xDEADBEEF with rlast=1.
- INCR write at 0x100, len 3, data 1,2,3,4; then INCR read, len 3 → rdata 1,2,3,4 on consecutive cycles, rlast only on beat 4.
- Write 0x11223344, then wstrb 0b0010 with wdata 0x0000AA00 → read returns 0x1122AA44.
- Read burst with rready low for 3 cycles at beat 2 → rdata and rlast held, no beat lost or duplicated; simultaneous write burst completes unaffected.
- FIXED write, len 3, data 5,6,7,8 to 0x200 → read 0x200 returns 8 and 0x204 is unchanged.
- Reset asserted during W beat 2 of 4 → all valid/ready outputs 0; arready and awready return 1 one cycle after release; a new burst completes. With the macro defined, first rvalid arrives exactly RespDelay+1 cycles after AR acceptance.
